sort4: RTL and testbench
========================

Name: sort4

Overview:
- Sequential 4-entry ascending sorter for Huffman tree-building nodes.
- Each 13-bit node is {weight[12:5], symbol/id[4:0]}. Only the weight is compared.
- On a start request it captures four nodes, sorts them over a short pipeline of compare-exchange stages, presents them smallest-first and raises a level done flag.
- Used as the front stage of larger insertion sorters, e.g. a 5-entry sorter. That sorter samples the done flag as a level over several cycles.

Parameters:
- W, 13, node width.
- KH, 12, key MSB index.
- KL, 5, key LSB index; key = node[KH:KL], bits below KL ride along uncompared.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- nRST  input  1  reset; asynchronous, active-low.
- sort_begin  input  1  start request, sampled on rising CLK.
- node0  input  13  unsorted entry, index 0.
- node1  input  13  unsorted entry, index 1.
- node2  input  13  unsorted entry, index 2.
- node3  input  13  unsorted entry, index 3.
- new1  output  13  sorted result, smallest key (registered).
- new2  output  13  sorted result, 2nd.
- new3  output  13  sorted result, 3rd.
- new4  output  13  sorted result, largest key.
- sort_over  output  1  done flag, level (registered).

Behaviour:
- Reset (nRST low, async) forces:
  - new1..new4 = 0, sort_over = 0;
  - state IDLE, internal working registers cleared.
  - Reset during a sort aborts it; no result is produced.
- States: IDLE, ST1, ST2, ST3, DONE.
- IDLE or DONE with sort_begin=1 at an edge:
  - capture node0..node3 into working regs w0..w3;
  - tag each with its 2-bit input index;
  - sort_over <= 0; go to ST1.
  - new1..new4 keep their previous values until the new result is written.
- Compare-exchange pairs and transitions:
  - ST1: pairs (w0,w1) and (w2,w3); go to ST2.
  - ST2: pairs (w0,w2) and (w1,w3); go to ST3.
  - ST3: pair (w1,w2); also write new1..new4 = w0..w3 (post-exchange, tags stripped); sort_over <= 1; go to DONE.
- Compare rule: compare-exchange puts the entry with the smaller {key, tag} in the lower slot. Equal keys therefore keep original input order (stable); low bits [4:0] never affect order.
- Latency: start sampled at edge E0. new1..new4 valid and sort_over=1 immediately after edge E3 (3 cycles after capture).
- DONE:
  - sort_over stays 1 and outputs hold stable indefinitely until a new sort_begin or reset. This lets a downstream stage sample the flag over multiple cycles.
  - sort_begin=1 in DONE restarts, as above.
- sort_begin while in ST1..ST3 is ignored; the in-flight sort completes unchanged.
- Input nodes need only be stable at the capture edge.
- Result ordering: key(new1) <= key(new2) <= key(new3) <= key(new4), unsigned 8-bit compare.
- No arithmetic on widths; data passes through unmodified.

Test Plan:
- Reset: assert nRST=0 mid-sort (after ST1) -> new1..4=0, sort_over=0 immediately. After release, outputs stay 0 with no sort_begin.
- Basic sort: node0=0x500 (key 40), node1=0x141 (key 10), node2=0x3C2 (key 30), node3=0x283 (key 20), one-cycle sort_begin -> after 3rd following edge, new1=0x141, new2=0x283, new3=0x3C2, new4=0x500, sort_over=1. sort_over must be 0 on the cycles before.
- Tie stability: node0=0x0A5, node1=0x0A1 (both key 5), node2=0x020 (key 1), node3=0x1FF (key 15) -> new1=0x020, new2=0x0A5, new3=0x0A1, new4=0x1FF.
- Hold: keep sort_begin low 10 cycles after done -> sort_over stays 1, outputs unchanged even if node inputs change.
- Restart and busy-ignore:
  - sort_begin in DONE with reversed keys 0x400, 0x300, 0x200, 0x100 -> sort_over drops next cycle, then rises 3 cycles after capture with new1..4=0x100, 0x200, 0x300, 0x400.
  - sort_begin pulses during ST2 are ignored.
- Already sorted and all-equal inputs (0x1E0 x4 with distinct low bits 0..3) -> outputs in input index order.

Source files
------------

// File: rtl/sort4.sv
// Four-entry ascending sorter for Huffman nodes: captures four nodes, sorts them
// on key through a three-stage compare-exchange network, and holds the result.
module sort4 #(
  parameter int W  = 13,
  parameter int KH = 12,
  parameter int KL = 5
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         sort_begin,
  input  logic [W-1:0] node0,
  input  logic [W-1:0] node1,
  input  logic [W-1:0] node2,
  input  logic [W-1:0] node3,
  output logic [W-1:0] new1,
  output logic [W-1:0] new2,
  output logic [W-1:0] new3,
  output logic [W-1:0] new4,
  output logic         sort_over
);

  typedef enum logic [2:0] {IDLE, ST1, ST2, ST3, DONE} state_t;

  state_t         state;
  // Working entries are {node, input index}; the index breaks key ties.
  logic [W+1:0]   w0, w1, w2, w3;
  logic [W+1:0]   x0, x1, x2, x3;

  function automatic logic [KH-KL+2:0] rank(input logic [W+1:0] e);
    return {e[KH+2:KL+2], e[1:0]};
  endfunction

  always_comb begin
    x0 = w0;
    x1 = w1;
    x2 = w2;
    x3 = w3;
    case (state)
      ST1: begin
        if (rank(w0) > rank(w1)) begin x0 = w1; x1 = w0; end
        if (rank(w2) > rank(w3)) begin x2 = w3; x3 = w2; end
      end
      ST2: begin
        if (rank(w0) > rank(w2)) begin x0 = w2; x2 = w0; end
        if (rank(w1) > rank(w3)) begin x1 = w3; x3 = w1; end
      end
      ST3: begin
        if (rank(w1) > rank(w2)) begin x1 = w2; x2 = w1; end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      w3        <= '0;
      new1      <= '0;
      new2      <= '0;
      new3      <= '0;
      new4      <= '0;
      sort_over <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (sort_begin) begin
            w0        <= {node0, 2'd0};
            w1        <= {node1, 2'd1};
            w2        <= {node2, 2'd2};
            w3        <= {node3, 2'd3};
            sort_over <= 1'b0;
            state     <= ST1;
          end
        end
        ST1: begin
          {w0, w1, w2, w3} <= {x0, x1, x2, x3};
          state            <= ST2;
        end
        ST2: begin
          {w0, w1, w2, w3} <= {x0, x1, x2, x3};
          state            <= ST3;
        end
        ST3: begin
          {w0, w1, w2, w3} <= {x0, x1, x2, x3};
          new1      <= x0[W+1:2];
          new2      <= x1[W+1:2];
          new3      <= x2[W+1:2];
          new4      <= x3[W+1:2];
          sort_over <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort4.sv
// Self-checking bench for sort4: directed cases plus random nodes compared
// against a stable insertion-sort reference on the 8-bit key.
module tb_sort4;

  typedef logic [12:0] node_t;
  typedef node_t arr4_t [4];

  logic  CLK = 1'b0;
  logic  nRST = 1'b0;
  logic  sort_begin = 1'b0;
  node_t node0 = '0, node1 = '0, node2 = '0, node3 = '0;
  node_t new1, new2, new3, new4;
  logic  sort_over;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 CLK = ~CLK;

  sort4 #(.W(13), .KH(12), .KL(5)) dut (
    .CLK(CLK), .nRST(nRST), .sort_begin(sort_begin),
    .node0(node0), .node1(node1), .node2(node2), .node3(node3),
    .new1(new1), .new2(new2), .new3(new3), .new4(new4),
    .sort_over(sort_over)
  );

  task automatic check(input string tag, input node_t got, input node_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stable insertion sort on key bits [12:5].
  function automatic arr4_t ref_sort(input arr4_t in);
    arr4_t o;
    node_t t;
    o = in;
    for (int i = 1; i < 4; i++)
      for (int j = i; j > 0 && o[j-1][12:5] > o[j][12:5]; j--) begin
        t = o[j]; o[j] = o[j-1]; o[j-1] = t;
      end
    return o;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_outs(input string tag, input arr4_t e);
    check({tag, "_new1"}, new1, e[0]);
    check({tag, "_new2"}, new2, e[1]);
    check({tag, "_new3"}, new3, e[2]);
    check({tag, "_new4"}, new4, e[3]);
  endtask

  // Run one sort; optionally poke sort_begin with fresh nodes while busy.
  task automatic do_sort(input string tag, input node_t a, b, c, d, input bit poke);
    arr4_t in;
    in = '{a, b, c, d};
    node0 = a; node1 = b; node2 = c; node3 = d;
    sort_begin = 1'b1;
    tick();
    sort_begin = 1'b0;
    check({tag, "_busy0"}, {12'd0, sort_over}, 13'd0);
    tick();
    check({tag, "_busy1"}, {12'd0, sort_over}, 13'd0);
    if (poke) begin
      node0 = node_t'($urandom); node1 = node_t'($urandom);
      node2 = node_t'($urandom); node3 = node_t'($urandom);
      sort_begin = 1'b1;
    end
    tick();
    check({tag, "_busy2"}, {12'd0, sort_over}, 13'd0);
    tick();
    sort_begin = 1'b0;
    check({tag, "_done"}, {12'd0, sort_over}, 13'd1);
    check_outs(tag, ref_sort(in));
  endtask

  initial begin
    arr4_t held;
    // Reset state
    #2;
    check("rst_new1", new1, '0);
    check("rst_over", {12'd0, sort_over}, '0);
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    do_sort("basic", 13'h500, 13'h141, 13'h3C2, 13'h283, 1'b0);
    check_outs("basic_lit", '{13'h141, 13'h283, 13'h3C2, 13'h500});

    do_sort("tie", 13'h0A5, 13'h0A1, 13'h020, 13'h1FF, 1'b0);
    check_outs("tie_lit", '{13'h020, 13'h0A5, 13'h0A1, 13'h1FF});

    // Hold: outputs frozen while inputs wander
    held = '{13'h020, 13'h0A5, 13'h0A1, 13'h1FF};
    for (int unsigned i = 0; i < 10; i++) begin
      node0 = node_t'($urandom); node1 = node_t'($urandom);
      node2 = node_t'($urandom); node3 = node_t'($urandom);
      tick();
      check("hold_over", {12'd0, sort_over}, 13'd1);
      check_outs("hold", held);
    end

    // Restart from DONE with reversed keys, pokes during ST2 ignored
    do_sort("rev", 13'h400, 13'h300, 13'h200, 13'h100, 1'b1);
    check_outs("rev_lit", '{13'h100, 13'h200, 13'h300, 13'h400});

    do_sort("eq", 13'h1E0, 13'h1E1, 13'h1E2, 13'h1E3, 1'b1);
    check_outs("eq_lit", '{13'h1E0, 13'h1E1, 13'h1E2, 13'h1E3});
    do_sort("sorted", 13'h020, 13'h040, 13'h060, 13'h1FF, 1'b0);

    // Reset mid-sort clears immediately and nothing is produced afterwards
    node0 = 13'h500; node1 = 13'h141; node2 = 13'h3C2; node3 = 13'h283;
    sort_begin = 1'b1;
    tick();
    sort_begin = 1'b0;
    tick();
    nRST = 1'b0;
    #1;
    check("mrst_over", {12'd0, sort_over}, '0);
    check_outs("mrst", '{13'h0, 13'h0, 13'h0, 13'h0});
    @(negedge CLK);
    nRST = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      tick();
      check("post_rst_over", {12'd0, sort_over}, '0);
      check("post_rst_new4", new4, '0);
    end

    // Random sorts; narrow key ranges half the time to force ties
    for (int unsigned k = 0; k < 150; k++) begin
      node_t r [4];
      for (int i = 0; i < 4; i++) begin
        r[i] = node_t'($urandom);
        if ($urandom_range(0, 1) == 1) r[i][12:5] = 8'($urandom_range(0, 3));
      end
      do_sort("rand", r[0], r[1], r[2], r[3], 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        tick();
        check("rand_hold", {12'd0, sort_over}, 13'd1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
